// File: rtl/aes_pkg.sv
// Shared types and constants for the AES inverse-cipher block sequencer.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    RUN,
    CAPT,
    OUT_WAIT
  } state_t;

  // Enabled core cycles from core release until state_out is valid.
  function automatic int run_cycles(input int nk);
    return (nk + 7) * 5 + 2;
  endfunction

endpackage

// File: rtl/aes_dec_out_buf.sv
// Result buffer between the sequencer and the plaintext sink (valid/ready).
// AES_DEC_CTRL_SKID_EN selects a 2-entry in-order buffer; otherwise a single register.
module aes_dec_out_buf
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AES_BLK_W-1:0] wr_data,
  output logic                 room,
  output logic                 room_after_wr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data
);

  logic       pop;
  logic [1:0] cnt;
  logic [1:0] cnt_left;

  assign pop      = out_valid & out_ready;
  assign cnt_left = cnt - {1'b0, pop};

`ifdef AES_DEC_CTRL_SKID_EN
  localparam logic [1:0] DEPTH = 2'd2;

  logic [AES_BLK_W-1:0] ent0;
  logic [AES_BLK_W-1:0] ent1;
  logic                 wr_ptr;
  logic                 rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent0   <= '0;
      ent1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr_en) begin
        if (wr_ptr) ent1 <= wr_data;
        else        ent0 <= wr_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt_left + {1'b0, wr_en};
    end
  end

  assign out_valid = (cnt != 2'd0);
  assign out_data  = rd_ptr ? ent1 : ent0;
`else
  localparam logic [1:0] DEPTH = 2'd1;

  logic [AES_BLK_W-1:0] data_r;
  logic                 valid_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (wr_en) begin
      data_r  <= wr_data;
      valid_r <= 1'b1;
    end else if (pop) begin
      valid_r <= 1'b0;
    end
  end

  assign cnt       = {1'b0, valid_r};
  assign out_valid = valid_r;
  assign out_data  = data_r;
`endif

  // Occupancy after this cycle's pop, with and without a write landing now.
  assign room          = (cnt_left < DEPTH);
  assign room_after_wr = ((cnt_left + 2'd1) < DEPTH);

endmodule

// File: rtl/aes_dec_ctrl.sv
// Sequencer around the AES inverse-cipher core: takes key and ciphertext, runs the core
// for a fixed cycle count, captures plaintext. AES_DEC_CTRL_SKID_EN enables a 2-entry result buffer.
//
//  state    | meaning
//  IDLE     | waiting for key_load or a ciphertext block
//  CRST     | one-cycle core reset to restart key expansion and round count
//  RUN      | core enabled, counting RUN_CYCLES
//  CAPT     | core state_out written into the result buffer
//  OUT_WAIT | result buffer full, waiting for the sink
module aes_dec_ctrl
  import aes_pkg::*;
#(
  parameter int nk         = 4,
  parameter int RUN_CYCLES = run_cycles(nk),
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [nk*32-1:0]     key_in,
  input  logic                 key_load,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 core_reset,
  output logic                 core_enable,
  output logic [AES_BLK_W-1:0] core_state,
  output logic [nk*32:0]       core_key,
  input  logic [AES_BLK_W-1:0] core_out
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [nk*32-1:0] key_reg;
  logic             key_ok;
  logic             accept;
  logic             ld_en;
  logic             run_done;
  logic             buf_wr;
  logic             buf_room;
  logic             buf_room_after_wr;

  // key_load takes priority over a block offered in the same cycle.
  assign ld_en    = key_load & (state == IDLE);
  assign in_ready = (state == IDLE) & key_ok & ~key_load & buf_room;
  assign accept   = in_valid & in_ready;
  assign run_done = (cnt == CNT_W'(RUN_CYCLES - 1));
  assign core_key = {1'b0, key_reg};

  always_comb begin
    state_nxt   = state;
    buf_wr      = 1'b0;
    core_enable = 1'b0;
    core_reset  = reset;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = CRST;
      end
      CRST: begin
        core_reset = 1'b1;
        state_nxt  = RUN;
      end
      RUN: begin
        core_enable = 1'b1;
        if (run_done) state_nxt = CAPT;
      end
      CAPT: begin
        buf_wr    = 1'b1;
        state_nxt = buf_room_after_wr ? IDLE : OUT_WAIT;
      end
      OUT_WAIT: begin
        if (buf_room) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      key_reg    <= '0;
      key_ok     <= 1'b0;
      core_state <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == RUN) ? cnt + CNT_W'(1) : '0;
      if (ld_en) begin
        key_reg <= key_in;
        key_ok  <= 1'b1;
      end
      if (accept) core_state <= in_data;
    end
  end

  aes_dec_out_buf u_out_buf (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (buf_wr),
    .wr_data      (core_out),
    .room         (buf_room),
    .room_after_wr(buf_room_after_wr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Scoreboard bench for aes_dec_ctrl with a stand-in core that only yields the plaintext
// after exactly the run length of enabled cycles since its last reset.
module tb_aes_dec_ctrl;

  localparam int RC4 = (4 + 7) * 5 + 2;
  localparam int RC8 = (8 + 7) * 5 + 2;
`ifdef AES_DEC_CTRL_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif
  localparam logic [255:0] K128  = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  logic clk, reset;
  logic [127:0] key_in;
  logic key_load, in_valid, in_ready, out_valid, out_ready, core_reset, core_enable;
  logic [127:0] in_data, out_data, core_state, core_out;
  logic [128:0] core_key;

  logic [255:0] key_in8;
  logic key_load8, in_valid8, in_ready8, out_valid8, out_ready8, core_reset8, core_enable8;
  logic [127:0] in_data8, out_data8, core_state8, core_out8;
  logic [256:0] core_key8;

  typedef struct {
    logic [127:0] d;
    int           t;
  } entry_t;

  entry_t       sb[$];
  int           checks = 0, failures = 0, cyc = 0, n_acc = 0;
  int           en4 = 0, en8 = 0;
  logic [127:0] tb_key = '0;

  // Known FIPS-197 vectors decrypt to PT; any other block maps to a keyed scramble.
  function automatic logic [127:0] plain_of(input logic [127:0] ct, input logic [255:0] key, input int nk);
    if (nk == 4 && key == K128 && ct == CT128) return PT;
    if (nk == 8 && key == K256 && ct == CT256) return PT;
    return ct ^ key[127:0] ^ key[255:128] ^ {ct[63:0], ct[127:64]};
  endfunction

  always @(posedge clk) begin
    if (core_reset) en4 <= 0;
    else if (core_enable) en4 <= en4 + 1;
    if (core_reset8) en8 <= 0;
    else if (core_enable8) en8 <= en8 + 1;
  end

  assign core_out = (en4 == RC4) ? plain_of(core_state, {128'b0, core_key[127:0]}, 4)
                                 : plain_of(core_state, {128'b0, core_key[127:0]}, 4) ^ {4{32'h5a5a_c3c3}};
  assign core_out8 = (en8 == RC8) ? plain_of(core_state8, core_key8[255:0], 8)
                                  : plain_of(core_state8, core_key8[255:0], 8) ^ {4{32'h5a5a_c3c3}};

  aes_dec_ctrl #(.nk(4)) u_dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_load(key_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_reset(core_reset), .core_enable(core_enable), .core_state(core_state),
    .core_key(core_key), .core_out(core_out)
  );

  aes_dec_ctrl #(.nk(8)) u_dut8 (
    .clk(clk), .reset(reset), .key_in(key_in8), .key_load(key_load8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .core_reset(core_reset8), .core_enable(core_enable8), .core_state(core_state8),
    .core_key(core_key8), .core_out(core_out8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=no-event required=event", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_valid && in_ready) && n < 100);
    if (!(in_valid && in_ready)) fail_now(nm);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now(nm);
  endtask

  // Monitor: latency, hold stability, ordering and data of every result leaving the DUT.
  initial begin
    logic         prev_ov = 1'b0, prev_or = 1'b0, busy_ok;
    logic [127:0] prev_d = '0;
    entry_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        prev_ov = 1'b0;
      end else begin
        busy_ok = (sb.size() == 0) || (SKID && sb.size() == 1 && out_valid);
        if (!busy_ok) chk("in_ready_busy", in_ready, 1'b0);
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) fail_now("unexpected_out_valid");
          else chk("latency", cyc, sb[0].t + RC4 + 2);
        end
        if (out_valid && prev_ov && !prev_or) chk("out_hold", out_data, prev_d);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) fail_now("unexpected_out_hs");
          else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.d);
          end
        end
        if (in_valid && in_ready) begin
          e.d = plain_of(in_data, {128'b0, tb_key}, 4);
          e.t = cyc + 1;
          sb.push_back(e);
          n_acc++;
        end
        prev_ov = out_valid;
        prev_or = out_ready;
        prev_d  = out_data;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, t8;
    reset = 1'b1; key_in = '0; key_load = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    key_in8 = '0; key_load8 = 1'b0; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_core_enable", core_enable, 1'b0);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_core_state", core_state, 128'h0);
    chk("rst_core_key", core_key, 129'h0);
    chk("rst_core_key8", core_key8[256], 1'b0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rel_core_reset", core_reset, 1'b0);

    // No key loaded: offered block must sit unaccepted.
    step();
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("nokey_in_ready", in_ready, 1'b0);
      chk("nokey_core_enable", core_enable, 1'b0);
    end

    // key_load beats a simultaneous block; the block goes in next cycle.
    step();
    key_load = 1'b1;
    key_in   = K128[127:0];
    in_data  = CT128;
    @(negedge clk);
    chk("load_wins_in_ready", in_ready, 1'b0);
    step();
    key_load = 1'b0;
    tb_key   = K128[127:0];
    @(negedge clk);
    chk("accept_after_load", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    drain("vec128_drain");

    // AES-256 vector on the nk=8 instance.
    step();
    key_load8 = 1'b1;
    key_in8   = K256;
    step();
    key_load8 = 1'b0;
    in_valid8 = 1'b1;
    in_data8  = CT256;
    @(negedge clk);
    chk("vec256_in_ready", in_ready8, 1'b1);
    t8 = cyc + 1;
    step();
    in_valid8 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid8 && n < 300);
    chk("vec256_latency", cyc, t8 + RC8 + 2);
    chk("vec256_data", out_data8, PT);
    step();
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    @(negedge clk);
    chk("vec256_released", out_valid8, 1'b0);

    // Random traffic with sink backpressure, key changes while idle, ignored loads while busy.
    n_acc = 0;
    for (int c = 0; c < 8000 && n_acc < 24; c++) begin
      step();
      key_load  = 1'b0;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      if (core_enable && $urandom_range(0, 15) == 0) begin
        key_load = 1'b1;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
      end else if (sb.size() == 0 && $urandom_range(0, 4) == 0) begin
        key_load = 1'b1;
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        tb_key   = key_in;
      end
    end
    if (n_acc < 24) fail_now("random_accept_count");
    step();
    key_load = 1'b0;
    drain("random_drain");

    // Held result: data stable, upstream readiness depends on buffer depth.
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    wait_accept("hold_accept");
    step();
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    if (!out_valid) fail_now("hold_out_valid");
    repeat (20) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, SKID);
    end
    step();
    drain("hold_drain");

    // Reset in the middle of a run drops the block and the key.
    step();
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    wait_accept("rst_run_accept");
    step();
    in_valid = 1'b0;
    n = 0;
    k = 0;
    while (k < 11 && n < 200) begin
      @(negedge clk);
      n++;
      if (core_enable) k++;
    end
    if (k < 11) fail_now("rst_run_start");
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_core_reset", core_reset, 1'b1);
    step();
    @(negedge clk);
    chk("midrst_core_enable", core_enable, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_core_reset2", core_reset, 1'b1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", in_ready, 1'b0);
    chk("postrst_core_key", core_key, 129'h0);
    chk("postrst_out_valid", out_valid, 1'b0);
    repeat (80) begin
      @(negedge clk);
      chk("postrst_no_out", out_valid, 1'b0);
    end

    step();
    key_load = 1'b1;
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    tb_key   = key_in;
    step();
    key_load = 1'b0;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    wait_accept("recover_accept");
    step();
    drain("recover_drain");

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
